// File: rtl/hash_drv_pkg.sv
// Shared types and helpers for the hash message driver.
//   state_t    : driver FSM states
//   bit_cnt_w  : width of the serializer bit counter for a given word width
//   fin_cnt_w  : width of the finalisation counter for a given zero-bit count
package hash_drv_pkg;

   localparam int unsigned DEF_WORD_W       = 8;
   localparam int unsigned DEF_DIGEST_W     = 32;
   localparam int unsigned DEF_FINAL_CYCLES = 64;

   typedef enum logic [2:0] {
      IDLE    = 3'd0,
      SHIFT   = 3'd1,
      GAP     = 3'd2,
      FINAL   = 3'd3,
      CAPTURE = 3'd4,
      DONE    = 3'd5
   } state_t;

   // At least one bit so a 1-bit word still has a legal counter.
   function automatic int unsigned bit_cnt_w(input int unsigned word_w);
      return (word_w > 1) ? $clog2(word_w) : 1;
   endfunction

   function automatic int unsigned fin_cnt_w(input int unsigned final_cycles);
      return $clog2(final_cycles + 1);
   endfunction

endpackage

// File: rtl/hash_drv_serializer.sv
// MSB-first word serializer for the hash driver.
//   clk, reset   : clock, synchronous active-high reset
//   load         : capture load_data/load_last, restart bit count
//   shift        : shift left one bit, advance bit count
//   load_data    : message word
//   load_last    : word is the last of its message
//   msb          : bit currently presented to the hash core
//   at_last_bit  : current bit is the final bit of the word
//   last_q       : loaded word was marked last
module hash_drv_serializer
   import hash_drv_pkg::*;
#(
   parameter int unsigned WORD_W = DEF_WORD_W
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              load,
   input  logic              shift,
   input  logic [WORD_W-1:0] load_data,
   input  logic              load_last,
   output logic              msb,
   output logic              at_last_bit,
   output logic              last_q
);

   localparam int unsigned BCW = bit_cnt_w(WORD_W);

   logic [WORD_W-1:0] shreg;
   logic [BCW-1:0]    bit_cnt;

   // Load has priority so a word accepted on the last bit streams without a gap.
   always_ff @(posedge clk) begin
      if (reset) begin
         shreg   <= '0;
         bit_cnt <= '0;
         last_q  <= 1'b0;
      end else if (load) begin
         shreg   <= load_data;
         bit_cnt <= '0;
         last_q  <= load_last;
      end else if (shift) begin
         shreg   <= shreg << 1;
         bit_cnt <= bit_cnt + BCW'(1);
      end
   end

   assign msb         = shreg[WORD_W-1];
   assign at_last_bit = (bit_cnt == BCW'(WORD_W - 1));

endmodule

// File: rtl/hash_msg_driver.sv
// Host-side driver for the root-of-trust hash core: serialises message words
// onto the core's injector bit, appends finalisation zeros, captures the
// core output and hands it back over a valid/ready handshake. Holds the core
// in reset while idle so each message starts from the same core state.
//   clk, reset     : clock, synchronous active-high reset
//   msg_*          : message word stream (valid/ready, last marks final word)
//   core_reset     : hash core reset (registered)
//   core_injector  : hash core injector bit
//   core_o         : hash core output
//   digest*        : captured digest stream (valid/ready)
//   underrun       : a gap occurred between words of this message
//   busy           : driver is not idle
module hash_msg_driver
   import hash_drv_pkg::*;
#(
   parameter int unsigned WORD_W       = DEF_WORD_W,
   parameter int unsigned DIGEST_W     = DEF_DIGEST_W,
   parameter int unsigned FINAL_CYCLES = DEF_FINAL_CYCLES
) (
   input  logic                clk,
   input  logic                reset,
   input  logic [WORD_W-1:0]   msg_data,
   input  logic                msg_valid,
   input  logic                msg_last,
   output logic                msg_ready,
   output logic                core_reset,
   output logic                core_injector,
   input  logic [DIGEST_W-1:0] core_o,
   output logic [DIGEST_W-1:0] digest,
   output logic                digest_valid,
   input  logic                digest_ready,
   output logic                underrun,
   output logic                busy
);

   localparam int unsigned FCW = fin_cnt_w(FINAL_CYCLES);

   state_t         state;
   state_t         next_state;
   logic [FCW-1:0] fin_cnt;
   logic           accept;
   logic           fin_done;
   logic           ser_msb;
   logic           ser_last_bit;
   logic           ser_last_q;
   logic           ser_shift;

   assign accept    = msg_valid & msg_ready;
   assign fin_done  = (fin_cnt == FCW'(FINAL_CYCLES - 1));
   // Hold the counter on the word's last bit; a reload or state change follows.
   assign ser_shift = (state == SHIFT) & ~ser_last_bit;

   hash_drv_serializer #(
      .WORD_W (WORD_W)
   ) u_ser (
      .clk         (clk),
      .reset       (reset),
      .load        (accept),
      .shift       (ser_shift),
      .load_data   (msg_data),
      .load_last   (msg_last),
      .msb         (ser_msb),
      .at_last_bit (ser_last_bit),
      .last_q      (ser_last_q)
   );

   // State register.
   always_ff @(posedge clk) begin
      if (reset) state <= IDLE;
      else       state <= next_state;
   end

   // Next-state logic.
   always_comb begin
      next_state = state;
      case (state)
         IDLE:    if (accept) next_state = SHIFT;
         SHIFT: begin
            if (ser_last_bit) begin
               if (accept)          next_state = SHIFT;
               else if (ser_last_q) next_state = FINAL;
               else                 next_state = GAP;
            end
         end
         GAP:     if (accept) next_state = SHIFT;
         FINAL:   if (fin_done) next_state = CAPTURE;
         CAPTURE: next_state = DONE;
         DONE:    if (digest_valid && digest_ready) next_state = IDLE;
         default: next_state = IDLE;
      endcase
   end

   // State-decoded outputs; none depend on msg_valid.
   always_comb begin
      msg_ready     = 1'b0;
      core_injector = 1'b0;
      busy          = (state != IDLE);
      case (state)
         IDLE:  msg_ready = 1'b1;
         SHIFT: begin
            core_injector = ser_msb;
            msg_ready     = ser_last_bit & ~ser_last_q;
         end
         GAP:   msg_ready = 1'b1;
         default: ;
      endcase
   end

   // Finalisation counter, core reset, digest capture and underrun flag.
   always_ff @(posedge clk) begin
      if (reset) begin
         fin_cnt      <= '0;
         core_reset   <= 1'b1;
         digest       <= '0;
         digest_valid <= 1'b0;
         underrun     <= 1'b0;
      end else begin
         fin_cnt <= (state == FINAL) ? fin_cnt + FCW'(1) : '0;
         case (state)
            IDLE: begin
               if (accept) begin
                  core_reset <= 1'b0;
                  underrun   <= 1'b0;
               end
            end
            GAP:     underrun <= 1'b1;
            CAPTURE: begin
               digest       <= core_o;
               digest_valid <= 1'b1;
            end
            DONE: begin
               if (digest_valid && digest_ready) begin
                  digest_valid <= 1'b0;
                  core_reset   <= 1'b1;
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_hash_msg_driver.sv
// Self-checking bench for hash_msg_driver with a behavioural hash core
// (CRC-style shift register) and a bit-list reference model.
module tb_hash_msg_driver;

   localparam int unsigned WORD_W       = 8;
   localparam int unsigned DIGEST_W     = 32;
   localparam int unsigned FINAL_CYCLES = 64;
   localparam logic [31:0] POLY = 32'h04C1_1DB7;
   localparam logic [31:0] SEED = 32'hFFFF_FFFF;

   logic                clk;
   logic                reset;
   logic [WORD_W-1:0]   msg_data;
   logic                msg_valid;
   logic                msg_last;
   logic                msg_ready;
   logic                core_reset;
   logic                core_injector;
   logic [DIGEST_W-1:0] core_o;
   logic [DIGEST_W-1:0] digest;
   logic                digest_valid;
   logic                digest_ready;
   logic                underrun;
   logic                busy;

   int total = 0;
   int bad   = 0;
   int edges = 0;

   logic [7:0]  w_q[$];
   int          g_q[$];
   logic        exp_bits[$];
   logic        absorbed[$];
   logic [31:0] stream_digest;

   hash_msg_driver #(
      .WORD_W       (WORD_W),
      .DIGEST_W     (DIGEST_W),
      .FINAL_CYCLES (FINAL_CYCLES)
   ) dut (
      .clk           (clk),
      .reset         (reset),
      .msg_data      (msg_data),
      .msg_valid     (msg_valid),
      .msg_last      (msg_last),
      .msg_ready     (msg_ready),
      .core_reset    (core_reset),
      .core_injector (core_injector),
      .core_o        (core_o),
      .digest        (digest),
      .digest_valid  (digest_valid),
      .digest_ready  (digest_ready),
      .underrun      (underrun),
      .busy          (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) edges <= edges + 1;

   function automatic logic [31:0] crc_step(input logic [31:0] s, input logic b);
      return {s[30:0], 1'b0} ^ ({32{s[31] ^ b}} & POLY);
   endfunction

   // Stand-in hash core: synchronous reset, always enabled.
   always @(posedge clk) begin
      if (core_reset) core_o <= SEED;
      else            core_o <= crc_step(core_o, core_injector);
   end

   // Record every bit the core absorbs since its reset was released.
   always @(posedge clk) begin
      if (core_reset) absorbed.delete();
      else            absorbed.push_back(core_injector);
   end

   // Expected absorbed bits: gap zeros, words MSB-first, then finalisation zeros.
   function automatic void build_exp();
      exp_bits.delete();
      foreach (w_q[k]) begin
         if (k > 0)
            for (int z = 0; z < g_q[k]; z++) exp_bits.push_back(1'b0);
         for (int b = WORD_W - 1; b >= 0; b--) exp_bits.push_back(w_q[k][b]);
      end
      for (int z = 0; z < int'(FINAL_CYCLES); z++) exp_bits.push_back(1'b0);
   endfunction

   function automatic logic [31:0] model_digest();
      logic [31:0] s;
      s = SEED;
      foreach (exp_bits[i]) s = crc_step(s, exp_bits[i]);
      return s;
   endfunction

   // Drive w_q/g_q as one message; wait for the digest. Leaves digest pending.
   task automatic run_msg(output logic [31:0] dg, output logic ur, output int lat,
                          output int bit_err, output bit to);
      int e0;
      int t;
      e0 = 0;
      to = 1'b0;
      for (int k = 0; k < w_q.size(); k++) begin
         msg_data  = w_q[k];
         msg_last  = (k == w_q.size() - 1);
         msg_valid = (g_q[k] == 0);
         t = 0;
         while (msg_ready !== 1'b1 && t < 200) begin
            @(negedge clk);
            t++;
         end
         if (t >= 200) to = 1'b1;
         repeat (g_q[k]) @(negedge clk);
         msg_valid = 1'b1;
         @(posedge clk);
         @(negedge clk);
         if (k == 0) e0 = edges;
      end
      msg_valid = 1'b0;
      msg_last  = 1'b0;
      t = 0;
      while (digest_valid !== 1'b1 && t < 1000) begin
         @(negedge clk);
         t++;
      end
      if (t >= 1000) to = 1'b1;
      lat = edges - e0;
      dg  = digest;
      ur  = underrun;
      bit_err = 0;
      if (absorbed.size() < exp_bits.size()) bit_err = exp_bits.size();
      else foreach (exp_bits[i]) if (absorbed[i] !== exp_bits[i]) bit_err++;
   endtask

   task automatic ack_digest(input int delay);
      repeat (delay) @(negedge clk);
      digest_ready = 1'b1;
      @(negedge clk);
      digest_ready = 1'b0;
   endtask

   task automatic test_reset();
      reset = 1'b1; msg_valid = 1'b0; msg_last = 1'b0; msg_data = '0; digest_ready = 1'b0;
      repeat (3) @(negedge clk);
      reset = 1'b0;
      repeat (5) @(negedge clk);
      total++; if (core_reset !== 1'b1) begin bad++; $display("FAIL reset_core_reset got=%b exp=1", core_reset); end
      total++; if (msg_ready !== 1'b1) begin bad++; $display("FAIL reset_msg_ready got=%b exp=1", msg_ready); end
      total++; if (core_injector !== 1'b0) begin bad++; $display("FAIL reset_injector got=%b exp=0", core_injector); end
      total++; if (digest_valid !== 1'b0) begin bad++; $display("FAIL reset_digest_valid got=%b exp=0", digest_valid); end
      total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b exp=0", busy); end
      total++; if (digest !== 32'h0 || underrun !== 1'b0) begin bad++; $display("FAIL reset_digest got=%h/%b exp=0/0", digest, underrun); end
   endtask

   task automatic test_single();
      logic [31:0] dg; logic ur; int lat; int be; bit to;
      w_q = '{8'hA5}; g_q = '{0};
      build_exp();
      run_msg(dg, ur, lat, be, to);
      total++; if (to) begin bad++; $display("FAIL single_timeout got=1 exp=0"); end
      total++; if (lat != 73) begin bad++; $display("FAIL single_latency got=%0d exp=73", lat); end
      total++; if (be != 0) begin bad++; $display("FAIL single_bits got=%0d errors exp=0", be); end
      total++; if (dg !== model_digest()) begin bad++; $display("FAIL single_digest got=%h exp=%h", dg, model_digest()); end
      total++; if (ur !== 1'b0) begin bad++; $display("FAIL single_underrun got=%b exp=0", ur); end
      ack_digest(0);
   endtask

   task automatic test_stream();
      logic [31:0] dg; logic ur; int lat; int be; bit to;
      w_q = '{8'h01, 8'hFF, 8'h80}; g_q = '{0, 0, 0};
      build_exp();
      run_msg(dg, ur, lat, be, to);
      stream_digest = dg;
      total++; if (to) begin bad++; $display("FAIL stream_timeout got=1 exp=0"); end
      total++; if (lat != 89) begin bad++; $display("FAIL stream_latency got=%0d exp=89", lat); end
      total++; if (be != 0) begin bad++; $display("FAIL stream_bits got=%0d errors exp=0", be); end
      total++; if (dg !== model_digest()) begin bad++; $display("FAIL stream_digest got=%h exp=%h", dg, model_digest()); end
      total++; if (ur !== 1'b0) begin bad++; $display("FAIL stream_underrun got=%b exp=0", ur); end
      ack_digest(2);
   endtask

   task automatic test_gap();
      logic [31:0] dg; logic ur; int lat; int be; bit to;
      w_q = '{8'h01, 8'hFF, 8'h80}; g_q = '{0, 3, 0};
      build_exp();
      run_msg(dg, ur, lat, be, to);
      total++; if (to) begin bad++; $display("FAIL gap_timeout got=1 exp=0"); end
      total++; if (lat != 92) begin bad++; $display("FAIL gap_latency got=%0d exp=92", lat); end
      total++; if (be != 0) begin bad++; $display("FAIL gap_bits got=%0d errors exp=0", be); end
      total++; if (dg !== model_digest()) begin bad++; $display("FAIL gap_digest got=%h exp=%h", dg, model_digest()); end
      total++; if (ur !== 1'b1) begin bad++; $display("FAIL gap_underrun got=%b exp=1", ur); end
      ack_digest(1);
   endtask

   task automatic test_done_hold();
      logic [31:0] dg; logic ur; int lat; int be; bit to; int t;
      w_q = '{8'h5A}; g_q = '{0};
      build_exp();
      run_msg(dg, ur, lat, be, to);
      total++; if (to || dg !== model_digest()) begin bad++; $display("FAIL hold_digest got=%h exp=%h", dg, model_digest()); end
      msg_data = 8'h3C; msg_last = 1'b1; msg_valid = 1'b1; digest_ready = 1'b0;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         total++;
         if (digest !== dg || msg_ready !== 1'b0 || digest_valid !== 1'b1) begin
            bad++; $display("FAIL hold_stable cyc=%0d got=%h/%b/%b exp=%h/0/1", i, digest, msg_ready, digest_valid, dg);
         end
      end
      digest_ready = 1'b1;
      @(negedge clk);
      digest_ready = 1'b0;
      total++;
      if (core_reset !== 1'b1 || digest_valid !== 1'b0 || msg_ready !== 1'b1 || digest !== dg) begin
         bad++; $display("FAIL hold_release got=%b/%b/%b/%h exp=1/0/1/%h", core_reset, digest_valid, msg_ready, digest, dg);
      end
      @(negedge clk);
      msg_valid = 1'b0; msg_last = 1'b0;
      total++; if (busy !== 1'b1 || core_reset !== 1'b0) begin bad++; $display("FAIL hold_pending_accept got=%b/%b exp=1/0", busy, core_reset); end
      t = 0;
      while (digest_valid !== 1'b1 && t < 1000) begin @(negedge clk); t++; end
      w_q = '{8'h3C}; g_q = '{0};
      build_exp();
      total++; if (digest !== model_digest()) begin bad++; $display("FAIL hold_pending_digest got=%h exp=%h", digest, model_digest()); end
      ack_digest(0);
   endtask

   task automatic test_reset_mid();
      logic [31:0] dg; logic ur; int lat; int be; bit to; int t;
      msg_data = 8'h01; msg_last = 1'b0; msg_valid = 1'b1;
      @(negedge clk);
      msg_valid = 1'b0;
      t = 0;
      while (msg_ready !== 1'b1 && t < 200) begin @(negedge clk); t++; end
      @(negedge clk);
      msg_data = 8'hFF; msg_valid = 1'b1;
      @(negedge clk);
      msg_valid = 1'b0;
      repeat (3) @(negedge clk);
      total++; if (underrun !== 1'b1 || busy !== 1'b1) begin bad++; $display("FAIL mid_pre_reset got=%b/%b exp=1/1", underrun, busy); end
      reset = 1'b1;
      @(negedge clk);
      total++;
      if (core_reset !== 1'b1 || core_injector !== 1'b0 || digest !== 32'h0 || digest_valid !== 1'b0 ||
          underrun !== 1'b0 || msg_ready !== 1'b1 || busy !== 1'b0) begin
         bad++; $display("FAIL mid_reset got=%b%b/%h/%b%b%b%b exp=10/00000000/0010",
                         core_reset, core_injector, digest, digest_valid, underrun, msg_ready, busy);
      end
      reset = 1'b0;
      @(negedge clk);
      w_q = '{8'h01, 8'hFF, 8'h80}; g_q = '{0, 0, 0};
      build_exp();
      run_msg(dg, ur, lat, be, to);
      total++; if (to || dg !== model_digest()) begin bad++; $display("FAIL mid_fresh_digest got=%h exp=%h", dg, model_digest()); end
      total++; if (dg !== stream_digest) begin bad++; $display("FAIL mid_fresh_repeat got=%h exp=%h", dg, stream_digest); end
      ack_digest(0);
   endtask

   task automatic test_random();
      logic [31:0] dg; logic ur; int lat; int be; bit to; int n; logic exp_ur;
      for (int m = 0; m < 8; m++) begin
         n = int'($urandom_range(1, 4));
         w_q.delete(); g_q.delete(); exp_ur = 1'b0;
         for (int k = 0; k < n; k++) begin
            w_q.push_back(8'($urandom));
            if (k > 0 && $urandom_range(0, 1) == 1) g_q.push_back(int'($urandom_range(1, 3)));
            else g_q.push_back(0);
            if (g_q[k] > 0) exp_ur = 1'b1;
         end
         build_exp();
         run_msg(dg, ur, lat, be, to);
         total++; if (to) begin bad++; $display("FAIL rand%0d_timeout got=1 exp=0", m); end
         total++; if (lat != exp_bits.size() + 1) begin bad++; $display("FAIL rand%0d_latency got=%0d exp=%0d", m, lat, exp_bits.size() + 1); end
         total++; if (be != 0) begin bad++; $display("FAIL rand%0d_bits got=%0d errors exp=0", m, be); end
         total++; if (dg !== model_digest()) begin bad++; $display("FAIL rand%0d_digest got=%h exp=%h", m, dg, model_digest()); end
         total++; if (ur !== exp_ur) begin bad++; $display("FAIL rand%0d_underrun got=%b exp=%b", m, ur, exp_ur); end
         ack_digest(int'($urandom_range(0, 4)));
      end
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog got=timeout exp=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      test_reset();
      test_single();
      test_stream();
      test_gap();
      test_done_hold();
      test_reset_mid();
      test_random();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
